// File: rtl/led_blink_pkg.sv
// Shared types and helpers for timed I/O blocks: blink FSM states and the
// millisecond-to-clock-cycle period conversion.
package led_blink_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF
  } blink_state_t;

  function automatic int unsigned msec_to_clocks(input int unsigned clocks_per_usec,
                                                 input int unsigned msec);
    return clocks_per_usec * msec * 32'd1000;
  endfunction

endpackage

// File: rtl/led_blinker_ms_timer.sv
// ms_timer: loadable down-counter that raises expire while enabled and at zero.
// A load in the expire cycle restarts the count for the next phase without a gap.
module ms_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = enable && (count == '0);

endmodule

// File: rtl/led_blinker.sv
// led_blinker: after a START pulse drives COUNT blinks (ON_MSEC on, OFF_MSEC off) on PIN.
// Build macro LED_BLINK_QUEUE_EN adds a one-deep pending request slot; otherwise PENDING is tied 0.
module led_blinker
  import led_blink_pkg::*;
#(
  parameter bit          ACTIVE_STATE    = 1'b1,
  parameter int unsigned CLOCKS_PER_USEC = 100,
  parameter int unsigned ON_MSEC         = 100,
  parameter int unsigned OFF_MSEC        = 100,
  parameter int unsigned COUNT_WIDTH     = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   START,
  input  logic [COUNT_WIDTH-1:0] COUNT,
  output logic                   PIN,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   PENDING
);

  localparam int unsigned ON_PERIOD   = msec_to_clocks(CLOCKS_PER_USEC, ON_MSEC);
  localparam int unsigned OFF_PERIOD  = msec_to_clocks(CLOCKS_PER_USEC, OFF_MSEC);
  localparam int unsigned MAX_PERIOD  = (ON_PERIOD > OFF_PERIOD) ? ON_PERIOD : OFF_PERIOD;
  localparam int unsigned TIMER_WIDTH = $clog2(MAX_PERIOD + 1);
  // Timer counts down to zero inclusive, so each phase loads its period minus one.
  localparam logic [TIMER_WIDTH-1:0] ON_LOAD  = TIMER_WIDTH'(ON_PERIOD - 1);
  localparam logic [TIMER_WIDTH-1:0] OFF_LOAD = TIMER_WIDTH'(OFF_PERIOD - 1);

  blink_state_t           state, state_next;
  logic [COUNT_WIDTH-1:0] blinks, blinks_next;
  logic                   pin_next, busy_next, done_next;
  logic                   timer_load, timer_expire;
  logic [TIMER_WIDTH-1:0] timer_value;
  logic                   req_valid;
  logic [COUNT_WIDTH-1:0] req_count;
`ifdef LED_BLINK_QUEUE_EN
  logic                   pending_next;
  logic [COUNT_WIDTH-1:0] slot, slot_next;
`endif

  ms_timer #(.WIDTH(TIMER_WIDTH)) u_timer (
    .CLK        (CLK),
    .RESET      (RESET),
    .enable     (state != IDLE),
    .load       (timer_load),
    .load_value (timer_value),
    .expire     (timer_expire)
  );

  always_comb begin
    state_next  = state;
    blinks_next = blinks;
    pin_next    = !ACTIVE_STATE;
    busy_next   = 1'b0;
    done_next   = 1'b0;
    timer_load  = 1'b0;
    timer_value = ON_LOAD;
    req_valid   = START;
    req_count   = COUNT;
`ifdef LED_BLINK_QUEUE_EN
    pending_next = PENDING;
    slot_next    = slot;
    // A fresh START in IDLE beats the queued request; latest request wins.
    if (START && (state != IDLE)) begin
      pending_next = 1'b1;
      slot_next    = COUNT;
    end else if ((state == IDLE) && !START && PENDING) begin
      req_valid = 1'b1;
      req_count = slot;
    end
    if ((state == IDLE) && req_valid) begin
      pending_next = 1'b0;
    end
`endif

    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_count != '0) begin
            state_next  = ON;
            blinks_next = req_count;
            pin_next    = ACTIVE_STATE;
            busy_next   = 1'b1;
            timer_load  = 1'b1;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      ON: begin
        busy_next = 1'b1;
        pin_next  = ACTIVE_STATE;
        if (timer_expire) begin
          state_next  = OFF;
          pin_next    = !ACTIVE_STATE;
          timer_load  = 1'b1;
          timer_value = OFF_LOAD;
          if (blinks != '0) begin
            blinks_next = blinks - 1'b1;
          end
        end
      end
      OFF: begin
        busy_next = 1'b1;
        if (timer_expire) begin
          if (blinks != '0) begin
            state_next = ON;
            pin_next   = ACTIVE_STATE;
            timer_load = 1'b1;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
`ifdef LED_BLINK_QUEUE_EN
            busy_next  = pending_next && (slot_next != '0);
`else
            busy_next  = 1'b0;
`endif
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      blinks  <= '0;
      PIN     <= !ACTIVE_STATE;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
`ifdef LED_BLINK_QUEUE_EN
      PENDING <= 1'b0;
      slot    <= '0;
`endif
    end else begin
      state   <= state_next;
      blinks  <= blinks_next;
      PIN     <= pin_next;
      BUSY    <= busy_next;
      DONE    <= done_next;
`ifdef LED_BLINK_QUEUE_EN
      PENDING <= pending_next;
      slot    <= slot_next;
`endif
    end
  end

`ifndef LED_BLINK_QUEUE_EN
  assign PENDING = 1'b0;
`endif

endmodule

// File: tb/tb_led_blinker.sv
// Directed self-checking bench for led_blinker with 1000/2000-cycle on/off periods;
// an active-high and an active-low instance share the same stimulus.
module tb_led_blinker;

  localparam int ON_CYC  = 1000;
  localparam int OFF_CYC = 2000;
`ifdef LED_BLINK_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif

  logic       CLK;
  logic       RESET;
  logic       START;
  logic [7:0] COUNT;
  logic       pin_hi, busy_hi, done_hi, pend_hi;
  logic       pin_lo, busy_lo, done_lo, pend_lo;

  int checks = 0;
  int failures = 0;
  int act_hi, act_lo, busy_cnt, done_cnt;
  logic pend_seen;

  led_blinker #(.ACTIVE_STATE(1'b1), .CLOCKS_PER_USEC(1), .ON_MSEC(1), .OFF_MSEC(2),
                .COUNT_WIDTH(8)) dut_hi (
    .CLK(CLK), .RESET(RESET), .START(START), .COUNT(COUNT),
    .PIN(pin_hi), .BUSY(busy_hi), .DONE(done_hi), .PENDING(pend_hi)
  );

  led_blinker #(.ACTIVE_STATE(1'b0), .CLOCKS_PER_USEC(1), .ON_MSEC(1), .OFF_MSEC(2),
                .COUNT_WIDTH(8)) dut_lo (
    .CLK(CLK), .RESET(RESET), .START(START), .COUNT(COUNT),
    .PIN(pin_lo), .BUSY(busy_lo), .DONE(done_lo), .PENDING(pend_lo)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Called on a falling edge; returns on the falling edge of the first sequence cycle.
  task automatic applyStimulus(input int count);
    START = 1'b1;
    COUNT = 8'(count);
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic stepCycle(input int idx, input int inject_at, input int inject_count);
    if (pin_hi)  act_hi++;
    if (!pin_lo) act_lo++;
    if (busy_hi) busy_cnt++;
    if (done_hi) done_cnt++;
    if (idx == inject_at) begin
      START = 1'b1;
      COUNT = 8'(inject_count);
    end else if ((inject_at >= 0) && (idx == inject_at + 1)) begin
      START = 1'b0;
      pend_seen = pend_hi;
    end
    @(negedge CLK);
  endtask

  task automatic quietCycles(input string tag, input int n);
    act_hi = 0; act_lo = 0; busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < n; i++) stepCycle(i, -1, 0);
    checkOutput({tag, "_pin_hi"}, act_hi, 0);
    checkOutput({tag, "_pin_lo"}, act_lo, 0);
    checkOutput({tag, "_busy"}, busy_cnt, 0);
    checkOutput({tag, "_done"}, done_cnt, 0);
  endtask

  task automatic checkSequence(input string tag, input int blinks, input int inject_at,
                               input int inject_count, input bit busy_at_done);
    int idx;
    int seq_busy, seq_done;
    idx = 0; seq_busy = 0; seq_done = 0; pend_seen = 1'b0;
    for (int b = 0; b < blinks; b++) begin
      act_hi = 0; act_lo = 0; busy_cnt = 0; done_cnt = 0;
      for (int i = 0; i < ON_CYC; i++) begin stepCycle(idx, inject_at, inject_count); idx++; end
      checkOutput($sformatf("%s_on%0d_hi", tag, b), act_hi, ON_CYC);
      checkOutput($sformatf("%s_on%0d_lo", tag, b), act_lo, ON_CYC);
      seq_busy += busy_cnt; seq_done += done_cnt;
      act_hi = 0; act_lo = 0; busy_cnt = 0; done_cnt = 0;
      for (int i = 0; i < OFF_CYC; i++) begin stepCycle(idx, inject_at, inject_count); idx++; end
      checkOutput($sformatf("%s_off%0d_hi", tag, b), act_hi, 0);
      checkOutput($sformatf("%s_off%0d_lo", tag, b), act_lo, 0);
      seq_busy += busy_cnt; seq_done += done_cnt;
    end
    checkOutput({tag, "_busy_cycles"}, seq_busy, blinks * (ON_CYC + OFF_CYC));
    checkOutput({tag, "_early_done"}, seq_done, 0);
    if (inject_at >= 0) checkOutput({tag, "_pending"}, pend_seen, QUEUE);
    checkOutput({tag, "_done"}, done_hi, 1);
    checkOutput({tag, "_busy_at_done"}, busy_hi, busy_at_done);
    checkOutput({tag, "_pin_at_done"}, pin_hi, 0);
    @(negedge CLK);
    checkOutput({tag, "_done_single"}, done_hi, 0);
  endtask

  initial begin
    RESET = 1'b1;
    START = 1'b0;
    COUNT = 8'd0;
    repeat (3) @(negedge CLK);
    checkOutput("reset_pin_hi", pin_hi, 0);
    checkOutput("reset_pin_lo", pin_lo, 1);
    checkOutput("reset_busy", busy_hi | busy_lo, 0);
    checkOutput("reset_done", done_hi | done_lo, 0);
    checkOutput("reset_pending", pend_hi | pend_lo, 0);
    RESET = 1'b0;
    quietCycles("idle", 100);

    applyStimulus(3);
    checkSequence("count3", 3, -1, 0, 1'b0);

    applyStimulus(0);
    checkOutput("zero_done", done_hi, 1);
    checkOutput("zero_busy", busy_hi, 0);
    checkOutput("zero_pin", pin_hi, 0);
    @(negedge CLK);
    quietCycles("zero_after", 20);

    applyStimulus(2);
    checkSequence("busy_start", 2, 500, 5, QUEUE);
`ifdef LED_BLINK_QUEUE_EN
    checkOutput("queue_pending_clear", pend_hi, 0);
    checkOutput("queue_busy_held", busy_hi, 1);
    checkSequence("queued5", 5, -1, 0, 1'b0);
`else
    quietCycles("ignored_start", 200);
`endif

    applyStimulus(4);
    repeat (1500) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    checkOutput("abort_pin_hi", pin_hi, 0);
    checkOutput("abort_pin_lo", pin_lo, 1);
    checkOutput("abort_busy", busy_hi, 0);
    checkOutput("abort_done", done_hi, 0);
    RESET = 1'b0;
    quietCycles("post_abort", 3000);
    applyStimulus(2);
    checkSequence("after_abort", 2, -1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
